// File: rtl/proc_mem.sv
// Multicycle register processor fetching instructions, immediates and LD/ST data
// over a request/ready memory handshake. R7 is the program counter.
//
// state | meaning
// IDLE  | waiting for Run
// FETCH | reading instruction word at PC
// EXEC  | decode; set up operands or memory address
// IMM   | reading immediate word at PC
// ALU   | G <= A +/- Ry, NZ updated
// WB    | Rx <= G
// MEMRD | load Rx from [Ry]
// MEMWR | store Rx to [Ry]
// DONE  | instruction complete, Done pulse
// HALT  | stopped until reset
module proc_mem #(
  parameter int unsigned       DATA_W   = 16,
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  input  logic              MemReady,
  output logic              MemReq,
  output logic              W,
  output logic [DATA_W-1:0] ADDR,
  output logic [DATA_W-1:0] DOUT,
  output logic              Done,
  output logic              Halted,
  output logic [DATA_W-1:0] BusWires
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_EXEC, S_IMM, S_ALU, S_WB, S_MEMRD, S_MEMWR, S_DONE, S_HALT
  } state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [DATA_W-1:0] r_q [8];
  logic [DATA_W-1:0] r_d [8];
  logic [8:0]        ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, g_q, g_d;
  logic [DATA_W-1:0] addr_q, addr_d, dout_q, dout_d, bus_q, bus_d;
  logic              nz_q, nz_d, memreq_q, memreq_d, w_q, w_d;
  logic              done_q, done_d, halted_q, halted_d;

  logic [2:0]        op, rx, ry;
  logic              xfer;
  logic [DATA_W-1:0] alu_res;

  assign op      = ir_q[8:6];
  assign rx      = ir_q[5:3];
  assign ry      = ir_q[2:0];
  assign xfer    = memreq_q & MemReady;
  assign alu_res = op[0] ? (a_q - r_q[ry]) : (a_q + r_q[ry]);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    ir_d    = ir_q;
    a_d     = a_q;
    g_d     = g_q;
    nz_d    = nz_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    bus_d   = bus_q;
    case (state_q)
      S_IDLE: begin
        if (Run) begin
          state_d = S_FETCH;
          addr_d  = r_q[7];
        end
      end
      S_FETCH: begin
        if (xfer) begin
          ir_d    = DIN[8:0];
          r_d[7]  = r_q[7] + ONE;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op)
          OP_MV: begin
            r_d[rx] = r_q[ry];
            bus_d   = r_q[ry];
            state_d = S_DONE;
          end
          OP_MVI: begin
            addr_d  = r_q[7];
            state_d = S_IMM;
          end
          OP_ADD, OP_SUB: begin
            a_d     = r_q[rx];
            bus_d   = r_q[rx];
            state_d = S_ALU;
          end
          OP_LD: begin
            addr_d  = r_q[ry];
            state_d = S_MEMRD;
          end
          OP_ST: begin
            addr_d  = r_q[ry];
            dout_d  = r_q[rx];
            state_d = S_MEMWR;
          end
          OP_MVNZ: begin
            if (nz_q) begin
              r_d[rx] = r_q[ry];
              bus_d   = r_q[ry];
            end
            state_d = S_DONE;
          end
          OP_HALT: state_d = S_HALT;
          default: state_d = S_IDLE;
        endcase
      end
      S_IMM: begin
        if (xfer) begin
          // PC increment first so an immediate loaded into R7 overrides it
          r_d[7]  = r_q[7] + ONE;
          r_d[rx] = DIN;
          bus_d   = DIN;
          state_d = S_DONE;
        end
      end
      S_ALU: begin
        g_d     = alu_res;
        nz_d    = (alu_res != '0);
        bus_d   = alu_res;
        state_d = S_WB;
      end
      S_WB: begin
        r_d[rx] = g_q;
        bus_d   = g_q;
        state_d = S_DONE;
      end
      S_MEMRD: begin
        if (xfer) begin
          r_d[rx] = DIN;
          bus_d   = DIN;
          state_d = S_DONE;
        end
      end
      S_MEMWR: begin
        if (xfer) state_d = S_DONE;
      end
      S_DONE: begin
        if (Run) begin
          state_d = S_FETCH;
          addr_d  = r_q[7];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    // strobes registered from the next state so they line up with it
    memreq_d = (state_d == S_FETCH) || (state_d == S_IMM) ||
               (state_d == S_MEMRD) || (state_d == S_MEMWR);
    w_d      = (state_d == S_MEMWR);
    done_d   = (state_d == S_DONE);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      for (int i = 0; i < 7; i++) r_q[i] <= '0;
      r_q[7]   <= PC_RESET;
      ir_q     <= '0;
      a_q      <= '0;
      g_q      <= '0;
      nz_q     <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      bus_q    <= '0;
      memreq_q <= 1'b0;
      w_q      <= 1'b0;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      g_q      <= g_d;
      nz_q     <= nz_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      bus_q    <= bus_d;
      memreq_q <= memreq_d;
      w_q      <= w_d;
      done_q   <= done_d;
      halted_q <= halted_d;
    end
  end

  assign MemReq   = memreq_q;
  assign W        = w_q;
  assign ADDR     = addr_q;
  assign DOUT     = dout_q;
  assign Done     = done_q;
  assign Halted   = halted_q;
  assign BusWires = bus_q;

endmodule

// File: tb/tb_proc_mem.sv
// Directed bench for proc_mem: table of single-instruction steps through one program,
// plus hand sequences for wait states, jump, halt and reset during a store.
module tb_proc_mem;
  localparam int DW = 16;

  logic          Clock = 1'b0;
  logic          Resetn, Run, MemReady;
  logic [DW-1:0] DIN;
  logic          MemReq, W, Done, Halted;
  logic [DW-1:0] ADDR, DOUT, BusWires;

  logic [15:0] mem [256];
  int checks = 0;
  int errors = 0;
  int st_count = 0;
  logic [15:0] st_addr, st_data;

  proc_mem #(.DATA_W(DW), .PC_RESET('0)) dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN), .MemReady(MemReady),
    .MemReq(MemReq), .W(W), .ADDR(ADDR), .DOUT(DOUT), .Done(Done),
    .Halted(Halted), .BusWires(BusWires)
  );

  assign DIN = (ADDR[15:8] == 8'h00) ? mem[ADDR[7:0]] : 16'hDEAD;

  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] ins;
    logic [15:0] imm;
    int          cyc;
    int          rx;
    logic [15:0] val;
    logic [15:0] bus;
    logic        nz;
  } vec_t;

  vec_t vt[15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // memory completes the write at the coming edge; sample #1 after it
  task automatic tick();
    if (MemReq && W && MemReady && ADDR[15:8] == 8'h00) begin
      mem[ADDR[7:0]] = DOUT;
      st_count++;
      st_addr = ADDR;
      st_data = DOUT;
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic exec_one(input int stall_n, output int cyc, output int bad,
                          output logic [15:0] first_addr);
    Run = 1'b1;
    MemReady = 1'b1;
    tick();
    Run = 1'b0;
    cyc = 1;
    bad = 0;
    first_addr = ADDR;
    while (!Done && cyc < 40) begin
      MemReady = (cyc > stall_n);
      if (cyc <= stall_n && (!MemReq || ADDR !== first_addr)) bad++;
      tick();
      cyc++;
    end
    MemReady = 1'b1;
    if (!Done) cyc = -1;
  endtask

  initial begin
    int a, cyc, bad, dseen;
    logic [15:0] fa, exp_pc;

    vt[0]  = '{16'h048, 16'h0003, 4, 1, 16'h0003, 16'h0003, 1'b0};
    vt[1]  = '{16'h081, 16'h0000, 5, 0, 16'h0008, 16'h0008, 1'b1};
    vt[2]  = '{16'h0D2, 16'h0000, 5, 2, 16'h0000, 16'h0000, 1'b0};
    vt[3]  = '{16'h198, 16'h0000, 3, 3, 16'h0000, 16'h0000, 1'b0};
    vt[4]  = '{16'h040, 16'hBEEF, 4, 0, 16'hBEEF, 16'hBEEF, 1'b0};
    vt[5]  = '{16'h058, 16'h0040, 4, 3, 16'h0040, 16'h0040, 1'b0};
    vt[6]  = '{16'h143, 16'h0000, 4, 0, 16'hBEEF, 16'h0040, 1'b0};
    vt[7]  = '{16'h123, 16'h0000, 4, 4, 16'hBEEF, 16'hBEEF, 1'b0};
    vt[8]  = '{16'h088, 16'h0000, 5, 1, 16'hBEF2, 16'hBEF2, 1'b1};
    vt[9]  = '{16'h198, 16'h0000, 3, 3, 16'hBEEF, 16'hBEEF, 1'b1};
    vt[10] = '{16'h0D0, 16'h0000, 5, 2, 16'h4111, 16'h4111, 1'b1};
    vt[11] = '{16'h032, 16'h0000, 3, 6, 16'h4111, 16'h4111, 1'b1};
    vt[12] = '{16'h0B0, 16'h0000, 5, 6, 16'h0000, 16'h0000, 1'b0};
    vt[13] = '{16'h068, 16'h0020, 4, 5, 16'h0020, 16'h0020, 1'b0};
    vt[14] = '{16'h03D, 16'h0000, 3, 7, 16'h0020, 16'h0020, 1'b0};

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h040;
    mem[1] = 16'h0005;
    a = 2;
    for (int i = 0; i < 15; i++) begin
      mem[a] = vt[i].ins;
      a++;
      if (vt[i].ins[8:6] == 3'b001) begin
        mem[a] = vt[i].imm;
        a++;
      end
    end
    mem[8'h20] = 16'h005;
    mem[8'h21] = 16'h1C0;

    Resetn = 1'b0; Run = 1'b0; MemReady = 1'b1;
    repeat (3) tick();
    check("rst_memreq", MemReq, 0);
    check("rst_w", W, 0);
    check("rst_addr", ADDR, 0);
    check("rst_dout", DOUT, 0);
    check("rst_done", Done, 0);
    check("rst_halted", Halted, 0);
    check("rst_bus", BusWires, 0);
    check("rst_pc", dut.r_q[7], 0);
    Resetn = 1'b1;
    tick();

    // mvi R0,#5 with zero wait states, cycle by cycle
    Run = 1'b1;
    tick();
    Run = 1'b0;
    check("t1_fetch_req", MemReq, 1);
    check("t1_fetch_addr", ADDR, 16'h0000);
    check("t1_fetch_done", Done, 0);
    tick();
    check("t1_exec_req", MemReq, 0);
    tick();
    check("t1_imm_req", MemReq, 1);
    check("t1_imm_addr", ADDR, 16'h0001);
    check("t1_imm_w", W, 0);
    tick();
    check("t1_done", Done, 1);
    check("t1_r0", dut.r_q[0], 16'h0005);
    check("t1_pc", dut.r_q[7], 16'h0002);
    check("t1_bus", BusWires, 16'h0005);

    exp_pc = 16'h0002;
    for (int i = 0; i < 15; i++) begin
      exec_one(0, cyc, bad, fa);
      exp_pc = (vt[i].rx == 7) ? vt[i].val
             : exp_pc + ((vt[i].ins[8:6] == 3'b001) ? 16'd2 : 16'd1);
      check($sformatf("v%0d_cycles", i), cyc, vt[i].cyc);
      check($sformatf("v%0d_reg", i), dut.r_q[vt[i].rx], vt[i].val);
      check($sformatf("v%0d_bus", i), BusWires, vt[i].bus);
      check($sformatf("v%0d_nz", i), dut.nz_q, vt[i].nz);
      check($sformatf("v%0d_pc", i), dut.r_q[7], exp_pc);
      if (i == 1) check("v1_g", dut.g_q, 16'h0008);
      if (i == 2) check("v2_g", dut.g_q, 16'h0000);
    end
    check("st_count", st_count, 1);
    check("st_addr", st_addr, 16'h0040);
    check("st_data", st_data, 16'hBEEF);

    // mv R0,R5 at the jump target with three wait states on the fetch
    exec_one(3, cyc, bad, fa);
    check("ws_first_addr", fa, 16'h0020);
    check("ws_stable", bad, 0);
    check("ws_cycles", cyc, 6);
    check("ws_r0", dut.r_q[0], 16'h0020);

    // halt
    Run = 1'b1;
    tick();
    Run = 1'b0;
    cyc = 1;
    dseen = 0;
    while (!Halted && cyc < 20) begin
      tick();
      cyc++;
      if (Done) dseen++;
    end
    check("halt_cycles", cyc, 3);
    check("halt_no_done", dseen, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      Run = i[0];
      tick();
      if (MemReq || Done || !Halted) bad++;
    end
    Run = 1'b0;
    check("halt_quiet", bad, 0);

    // reset out of halt, then reset abandoning a stalled store
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    check("unhalt", Halted, 0);
    mem[2] = 16'h143;
    exec_one(0, cyc, bad, fa);
    check("t6_mvi_cycles", cyc, 4);
    Run = 1'b1;
    tick();
    Run = 1'b0;
    tick();
    MemReady = 1'b0;
    tick();
    check("t6_memwr_req", MemReq, 1);
    check("t6_memwr_w", W, 1);
    check("t6_memwr_addr", ADDR, 16'h0000);
    check("t6_memwr_dout", DOUT, 16'h0005);
    tick();
    check("t6_stall_w", W, 1);
    check("t6_stall_dout", DOUT, 16'h0005);
    Resetn = 1'b0;
    tick();
    check("t6_rst_req", MemReq, 0);
    check("t6_rst_w", W, 0);
    check("t6_rst_done", Done, 0);
    check("t6_rst_halted", Halted, 0);
    check("t6_rst_pc", dut.r_q[7], 16'h0000);
    Resetn = 1'b1;
    MemReady = 1'b1;
    check("t6_no_write", mem[0], 16'h0040);
    exec_one(0, cyc, bad, fa);
    check("t6_restart_addr", fa, 16'h0000);
    check("t6_restart_cycles", cyc, 4);
    check("t6_restart_r0", dut.r_q[0], 16'h0005);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_mem.md
Name: proc_mem

Overview:
- Parametrised multicycle successor to the team's 3-bit-opcode processor.
- Generalises the data/address width and fetches instructions and immediates from external memory through a request/ready handshake with wait states.
- Implements real LD/ST memory cycles, a registered non-zero flag for MVNZ, and a HALT instruction.
- Sits between the test memory and the system bus; R7 is the program counter.

Parameters:
DATA_W, 16, data, register and address width; must be >= 9
PC_RESET, 0, PC value loaded on reset

Ports:
Clock  in  1  system clock, all state on posedge
Resetn  in  1  synchronous active-low reset
Run  in  1  start/continue; sampled only in IDLE and DONE
DIN  in  DATA_W  memory read data; valid when MemReq=1 and MemReady=1
MemReady  in  1  memory completes the current transfer this cycle
MemReq  out  1  memory transfer request
W  out  1  write strobe; only ever 1 while MemReq=1
ADDR  out  DATA_W  registered memory address
DOUT  out  DATA_W  registered store data
Done  out  1  one-cycle pulse per completed instruction
Halted  out  1  high after HALT executes, until reset
BusWires  out  DATA_W  registered copy of the last value written to any of R0-R7, A or G

Behaviour:
- Clock and reset: one clock, Clock. Resetn is synchronous and active-low.
- Reset values: state=IDLE, R0-R6=0, PC=PC_RESET, IR=0, A=0, G=0, NZ=0, ADDR=0, DOUT=0. All outputs are 0.
- Instruction format: IR[8:6]=op, IR[5:3]=X, IR[2:0]=Y; IR[DATA_W-1:9] is ignored. Register index 7 is the PC.
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 ld, 101 st, 110 mvnz, 111 halt.
- MemReq=1 exactly in states FETCH, IMM, MEMRD, MEMWR; W=1 only in MEMWR.
- ADDR, DOUT and W stay stable while MemReq=1.
- A transfer completes at the posedge where MemReq=1 and MemReady=1. MemReady is ignored when MemReq=0.
- State transitions:
  - IDLE: Run=1 -> FETCH, ADDR<=PC.
  - FETCH: on ready, IR<=DIN, PC<=PC+1 -> EXEC.
  - EXEC, by opcode:
    - mv: Rx<=Ry -> DONE.
    - mvi: ADDR<=PC -> IMM.
    - add/sub: A<=Rx -> ALU.
    - ld: ADDR<=Ry -> MEMRD.
    - st: ADDR<=Ry, DOUT<=Rx -> MEMWR.
    - mvnz: if NZ=1 then Rx<=Ry -> DONE.
    - halt: -> HALT.
  - IMM: on ready, Rx<=DIN and PC<=PC+1 (when X=7, PC<=DIN wins) -> DONE.
  - ALU: G<=A+Ry or A-Ry, modulo 2^DATA_W; NZ<=(result!=0) -> WB.
  - WB: Rx<=G -> DONE.
  - MEMRD: on ready, Rx<=DIN -> DONE.
  - MEMWR: on ready -> DONE.
  - DONE: Done=1; if Run=1 -> FETCH with ADDR<=PC, else -> IDLE.
  - HALT: Halted=1, no MemReq; left only by reset.
- Latency with zero wait states:
  - mv/mvnz/halt-entry: 3 cycles (halt: FETCH, EXEC, then HALT).
  - mvi/ld/st: 4 cycles.
  - add/sub: 5 cycles.
  - Each cycle with MemReady=0 while MemReq=1 adds 1 cycle.
- Writes to X=7 load the PC (jump). The next fetch uses the new PC.
- NZ changes only in ALU. mv/mvi/ld do not affect NZ.
- Run=0 mid-instruction does not abort; the instruction completes, then the block goes to IDLE.
- Resetn=0 in any state, including mid-transfer: next edge drops MemReq and W to 0 and loads reset values. A memory transfer in flight is abandoned.

Test Plan:
1. Reset, Run=1, memory [0]=0x040, [1]=0x0005, MemReady tied 1 -> MemReq cycles at ADDR 0 then 1; Done pulses in the 4th cycle after leaving IDLE; R0=5, PC=2, BusWires=5.
2. Program mvi R1,#3 (0x048, 3); add R0,R1 (0x081); sub R2,R2 (0x0D2); mvnz R3,R0 (0x198) -> R0=8, G=8; R2=0, NZ=0; R3 unchanged (0); add takes 5 cycles.
3. Hold MemReady=0 for 3 cycles during a fetch -> MemReq=1 and ADDR constant throughout; instruction completes exactly 3 cycles later than zero-wait.
4. R0=0xBEEF, R3=0x0040: st (0x143) -> one transfer with W=1, ADDR=0x0040, DOUT=0xBEEF. Then ld R4,[R3] (0x123) returning 0xBEEF -> R4=0xBEEF, W=0.
5. R5=0x0020: mv R7,R5 (0x03D) -> next fetch ADDR=0x0020. halt (0x1C0) -> Halted=1, no Done, MemReq stays 0 for 20 cycles regardless of Run.
6. Resetn=0 for one cycle while in MEMWR with MemReady=0 -> next edge MemReq=0, W=0, PC=PC_RESET, Done=0, Halted=0; restart with Run=1 fetches from ADDR=PC_RESET.
